registers: RTL and testbench
============================

Name: registers

Overview:
- Dual-bank register file for the single-cycle CPU datapath: 32 integer registers and 32 floating-point registers, each 32 bits wide.
- Provides two combinational read ports (busA from rs, busB from rt) and one synchronous write port (busW).
- The write destination is either rd or rt, selected by regdst.
- fpoint selects the bank used for both the reads and the write in the current cycle.

Parameters:
- DATA_W, 32, width of each register and of every data bus.
- ADDR_W, 5, register index width.
- NREGS, 32, registers per bank (2**ADDR_W).

Ports:
- clk  in  1  system clock; writes occur on the rising edge.
- rst_n  in  1  asynchronous active-low reset; clears both banks.
- write  in  1  write enable (1 = write busW this cycle).
- regdst  in  1  write-address select: 1 = rd, 0 = rt.
- fpoint  in  1  bank select: 0 = integer bank, 1 = floating-point bank.
- rd  in  ADDR_W  destination index (used when regdst=1).
- rs  in  ADDR_W  read index for busA.
- rt  in  ADDR_W  read index for busB; also the write index when regdst=0.
- busW  in  DATA_W  write data.
- busA  out  DATA_W  contents of bank[fpoint][rs].
- busB  out  DATA_W  contents of bank[fpoint][rt].

Behaviour:
- Reset:
  - rst_n low asynchronously clears all 64 registers to 0, independent of clk.
  - While rst_n is low, busA and busB read 0 and writes are ignored.
- Write:
  - On posedge clk with rst_n=1 and write=1, waddr = regdst ? rd : rt.
  - bank[fpoint][waddr] <= busW.
  - write=0 leaves all registers unchanged.
- Read:
  - Purely combinational, zero latency.
  - busA = bank[fpoint][rs] and busB = bank[fpoint][rt], updating immediately on any change of rs, rt, fpoint or the register contents.
- Integer register 0:
  - Hardwired to 0: reads return 0 and writes to it are discarded.
  - Floating-point register f0 is an ordinary writable register.
- Read during write, same address:
  - Before the clock edge, the read ports return the old value (no write-through bypass).
  - The new value appears combinationally right after the edge.
- Both read ports may address the same register at the same time; both return identical data.
- The banks are fully independent: a write with fpoint=1 never changes the integer bank, and the reverse also holds.
- Unknown (X) values on write or regdst while rst_n=1 produce no requirement; the bench drives known values.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and ADDR_W constants.
  - Typedefs reg_addr_t (logic [ADDR_W-1:0]) and word_t (logic [DATA_W-1:0]).
  - Enum bank_sel_t: INT=0, FP=1.
- One sub-module, reg_bank:
  - Contains 32 x DATA_W storage, async reset, one write port, two combinational read ports.
  - Has a parameter ZERO_R0 that enables the hardwired r0.
  - Instantiated twice: integer bank with ZERO_R0=1, FP bank with ZERO_R0=0.
- The top level decodes fpoint into the per-bank write enables, applies the regdst address mux, and muxes the bank outputs onto busA and busB.

Test Plan:
- Reset: drive rst_n=0 mid-simulation after writes, then rs=1, rt=2 -> busA=0 and busB=0 immediately, with no clock edge needed.
- Integer write/read:
  - write=1, regdst=1, fpoint=0, rd=1, busW=1, one posedge.
  - Then write=0, rs=1, rt=1 -> busA=1, busB=1.
- Second write and dual read:
  - rd=2, busW=2, posedge, write=0.
  - Then rs=1, rt=2 -> busA=1, busB=2.
- regdst=0 path:
  - write=1, regdst=0, rt=5, rd=6, busW=0xDEADBEEF, posedge.
  - Then rs=5 -> busA=0xDEADBEEF; rs=6 -> busA=0.
- Bank isolation:
  - fpoint=1, rd=1, busW=0x3F800000, posedge.
  - Then fpoint=1, rs=1 -> busA=0x3F800000; fpoint=0, rs=1 -> busA=1 (integer value unchanged).
- Register zero:
  - Integer write of 0x1234 to rd=0 -> reading rs=0 with fpoint=0 gives 0.
  - The same write with fpoint=1 -> reading rs=0 gives 0x1234.
  - A write held with write=0 across an edge changes nothing.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared widths, typedefs and bank-select encoding for the
//           dual-bank CPU register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    INT = 1'b0,
    FP  = 1'b1
  } bank_sel_t;

  function automatic reg_addr_t sel_waddr(input logic regdst,
                                          input reg_addr_t rd,
                                          input reg_addr_t rt);
    return regdst ? rd : rt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank.sv
// ============================================================================
// Module  : reg_bank
// Purpose : One 32-entry register bank with async reset, one write port and
//           two combinational read ports; entry 0 optionally hardwired to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank #(
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] w_row [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_row
    if (ZERO_R0 && (gi == 0)) begin : g_hardwired
      // No storage: writes to this entry simply have nowhere to land.
      assign w_row[gi] = '0;
    end else begin : g_flop
      logic              w_we;
      logic [DATA_W-1:0] r_q;

      assign w_we = i_we && (i_waddr == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_we) begin
          r_q <= i_wdata;
        end
      end

      assign w_row[gi] = r_q;
    end
  end

  assign o_rdata_a = w_row[i_raddr_a];
  assign o_rdata_b = w_row[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/registers.sv
// ============================================================================
// Module  : registers
// Purpose : Integer + floating-point register file; fpoint picks the bank for
//           both reads and the write in the current cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module registers
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      write,
  input  logic      regdst,
  input  logic      fpoint,
  input  reg_addr_t rd,
  input  reg_addr_t rs,
  input  reg_addr_t rt,
  input  word_t     busW,
  output word_t     busA,
  output word_t     busB
);

  bank_sel_t w_bank;
  reg_addr_t w_waddr;
  logic      w_we_int;
  logic      w_we_fp;
  word_t     w_int_a;
  word_t     w_int_b;
  word_t     w_fp_a;
  word_t     w_fp_b;

  assign w_bank   = bank_sel_t'(fpoint);
  assign w_waddr  = sel_waddr(regdst, rd, rt);
  assign w_we_int = write && (w_bank == INT);
  assign w_we_fp  = write && (w_bank == FP);

  reg_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ZERO_R0(1'b1)
  ) u_int_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we_int),
    .i_waddr  (w_waddr),
    .i_wdata  (busW),
    .i_raddr_a(rs),
    .i_raddr_b(rt),
    .o_rdata_a(w_int_a),
    .o_rdata_b(w_int_b)
  );

  reg_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ZERO_R0(1'b0)
  ) u_fp_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we_fp),
    .i_waddr  (w_waddr),
    .i_wdata  (busW),
    .i_raddr_a(rs),
    .i_raddr_b(rt),
    .o_rdata_a(w_fp_a),
    .o_rdata_b(w_fp_b)
  );

  assign busA = (w_bank == FP) ? w_fp_a : w_int_a;
  assign busB = (w_bank == FP) ? w_fp_b : w_int_b;

endmodule

`default_nettype wire

// File: tb/tb_registers.sv
// ============================================================================
// Module  : tb_registers
// Purpose : Directed self-checking bench for the dual-bank register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_registers;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        regdst;
  logic        fpoint;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] busW;
  logic [31:0] busA;
  logic [31:0] busB;

  int checks   = 0;
  int failures = 0;

  registers dut (
    .clk   (clk),
    .rst_n (rst_n),
    .write (write),
    .regdst(regdst),
    .fpoint(fpoint),
    .rd    (rd),
    .rs    (rs),
    .rt    (rt),
    .busW  (busW),
    .busA  (busA),
    .busB  (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge, then settle 1 time unit after it.
  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; regdst = 1'b0; fpoint = 1'b0;
    rd = 5'd0; rs = 5'd1; rt = 5'd2; busW = 32'h0;
    #2;
    chk("reset_busA", busA, 32'h0);
    chk("reset_busB", busB, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Integer write r1 = 1; before the edge the old value is visible
    write = 1'b1; regdst = 1'b1; fpoint = 1'b0; rd = 5'd1; busW = 32'd1;
    rs = 5'd1; rt = 5'd1;
    #1;
    chk("rdw_old_value", busA, 32'h0);
    edge_settle();
    chk("rdw_new_value", busA, 32'd1);
    @(negedge clk);
    write = 1'b0;
    #1;
    chk("int_r1_busA", busA, 32'd1);
    chk("int_r1_busB", busB, 32'd1);

    // r2 = 2, dual read
    @(negedge clk);
    write = 1'b1; rd = 5'd2; busW = 32'd2;
    edge_settle();
    @(negedge clk);
    write = 1'b0; rs = 5'd1; rt = 5'd2;
    #1;
    chk("dual_busA_r1", busA, 32'd1);
    chk("dual_busB_r2", busB, 32'd2);

    // regdst=0 writes to rt
    @(negedge clk);
    write = 1'b1; regdst = 1'b0; rt = 5'd5; rd = 5'd6; busW = 32'hDEADBEEF;
    edge_settle();
    @(negedge clk);
    write = 1'b0; rs = 5'd5;
    #1;
    chk("regdst0_rt5_busA", busA, 32'hDEADBEEF);
    chk("regdst0_rt5_busB", busB, 32'hDEADBEEF);
    rs = 5'd6;
    #1;
    chk("regdst0_rd6_untouched", busA, 32'h0);

    // FP bank write f1, integer r1 stays
    @(negedge clk);
    write = 1'b1; regdst = 1'b1; fpoint = 1'b1; rd = 5'd1; busW = 32'h3F800000;
    edge_settle();
    @(negedge clk);
    write = 1'b0; rs = 5'd1; rt = 5'd2;
    #1;
    chk("fp_f1", busA, 32'h3F800000);
    chk("fp_f2_empty", busB, 32'h0);
    fpoint = 1'b0;
    #1;
    chk("int_r1_isolated", busA, 32'd1);
    chk("int_r2_isolated", busB, 32'd2);

    // Register zero: int discards, FP keeps
    @(negedge clk);
    write = 1'b1; regdst = 1'b1; fpoint = 1'b0; rd = 5'd0; busW = 32'h1234;
    edge_settle();
    @(negedge clk);
    write = 1'b0; rs = 5'd0; rt = 5'd0;
    #1;
    chk("int_r0_hardwired_A", busA, 32'h0);
    chk("int_r0_hardwired_B", busB, 32'h0);
    @(negedge clk);
    write = 1'b1; fpoint = 1'b1;
    edge_settle();
    @(negedge clk);
    write = 1'b0;
    #1;
    chk("fp_f0_writable", busA, 32'h1234);
    fpoint = 1'b0;
    #1;
    chk("int_r0_after_fp_write", busA, 32'h0);

    // Top index boundary
    @(negedge clk);
    write = 1'b1; rd = 5'd31; busW = 32'hFFFFFFFF;
    edge_settle();
    @(negedge clk);
    write = 1'b0; rs = 5'd31; rt = 5'd30;
    #1;
    chk("int_r31", busA, 32'hFFFFFFFF);
    chk("int_r30_empty", busB, 32'h0);

    // write=0 held across an edge changes nothing
    @(negedge clk);
    write = 1'b0; rd = 5'd1; busW = 32'hAAAA5555; rs = 5'd1;
    edge_settle();
    chk("write0_no_change", busA, 32'd1);

    // Asynchronous reset mid-cycle, no clock edge needed
    @(negedge clk);
    #2;
    rst_n = 1'b0; rs = 5'd1; rt = 5'd2; fpoint = 1'b0;
    #1;
    chk("async_rst_busA", busA, 32'h0);
    chk("async_rst_busB", busB, 32'h0);
    fpoint = 1'b1; rt = 5'd0;
    #1;
    chk("async_rst_fp_f1", busA, 32'h0);
    chk("async_rst_fp_f0", busB, 32'h0);

    // Writes ignored while in reset
    write = 1'b1; regdst = 1'b1; rd = 5'd1; busW = 32'h5A5A5A5A;
    edge_settle();
    chk("write_in_reset_ignored", busA, 32'h0);
    @(negedge clk);
    write = 1'b0; rst_n = 1'b1;
    #1;
    chk("after_reset_release", busA, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
